timing_nco: RTL and testbench

TIMING_NCO -- requirements
Module: timing_nco

---
 rtl/msk_rx_pkg.sv | 13 +
 rtl/ctrl_sat.sv | 27 ++
 rtl/timing_nco.sv | 110 +++++++++++
 tb/tb_timing_nco.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/msk_rx_pkg.sv
// rtl/msk_rx_pkg.sv - shared NCO state encoding and default datapath widths
package msk_rx_pkg;

    typedef enum logic {
        ACQ   = 1'b0,
        TRACK = 1'b1
    } nco_state_t;

    localparam int WCTRL = 18;
    localparam int WACC  = 24;
    localparam int WMU   = 16;

endpackage

// File: rtl/ctrl_sat.sv
// rtl/ctrl_sat.sv - combinational symmetric signed saturation to +/-LIM
module ctrl_sat #(
    parameter int W   = 18,
    parameter int LIM = 65535
) (
    input  logic signed [W-1:0] din,
    output logic signed [W-1:0] dout
);

    // One guard bit so LIM and -LIM are representable for any legal LIM.
    localparam logic signed [W:0] POS = (W+1)'(LIM);
    localparam logic signed [W:0] NEG = -POS;

    logic signed [W:0] ext;

    always_comb begin
        ext = {din[W-1], din};
        if (ext > POS) begin
            dout = POS[W-1:0];
        end else if (ext < NEG) begin
            dout = NEG[W-1:0];
        end else begin
            dout = din;
        end
    end

endmodule

// File: rtl/timing_nco.sv
// rtl/timing_nco.sv - symbol timing NCO with acquisition/tracking control and fractional interval output
module timing_nco #(
    parameter int WCTRL    = msk_rx_pkg::WCTRL,
    parameter int WACC     = msk_rx_pkg::WACC,
    parameter int SPS_LOG2 = 2,
    parameter int WMU      = msk_rx_pkg::WMU,
    parameter int CTRL_LIM = 65535,
    parameter int ACQ_SYMS = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    sample_val_i,
    input  logic signed [WCTRL-1:0] ctrl_i,
    input  logic                    ctrl_val_i,
    input  logic                    resync_i,
    output logic                    strobe_o,
    output logic [WMU-1:0]          mu_o,
    output logic                    locked_o,
    output logic [15:0]             sym_cnt_o
);

    localparam logic [WACC:0] NOM_INC = (WACC+1)'(1) << (WACC - SPS_LOG2);
    localparam int            WCNT    = $clog2(ACQ_SYMS + 1);
    localparam logic [WCNT-1:0] ACQ_LAST = WCNT'(ACQ_SYMS - 1);

    // The clamp must keep every step positive and below two nominal steps,
    // otherwise one sample could wrap twice or never advance.
    if (64'(CTRL_LIM) >= (64'(1) << (WACC - SPS_LOG2 - 1))) begin : g_lim_check
        $error("timing_nco: CTRL_LIM must be below NOM_INC/2");
    end

    msk_rx_pkg::nco_state_t  state;
    logic [WACC-1:0]         acc;
    logic signed [WCTRL-1:0] ctrl_q;
    logic signed [WCTRL-1:0] sat_ctrl;
    logic [WCNT-1:0]         acq_cnt;
    logic [WACC:0]           eff_ctrl;
    logic [WACC:0]           sum;
    logic [WACC-1:0]         residual;
    logic                    wrap;
    logic                    mu_ovf;
    logic [WMU-1:0]          mu_next;

    ctrl_sat #(
        .W   (WCTRL),
        .LIM (CTRL_LIM)
    ) u_ctrl_sat (
        .din  (ctrl_i),
        .dout (sat_ctrl)
    );

    always_comb begin
        eff_ctrl = '0;
        if (state == msk_rx_pkg::TRACK) begin
            eff_ctrl = {{(WACC + 1 - WCTRL){ctrl_q[WCTRL-1]}}, ctrl_q};
        end
    end

    assign sum      = {1'b0, acc} + NOM_INC + eff_ctrl;
    assign wrap     = sample_val_i & sum[WACC];
    assign residual = sum[WACC-1:0];

    // Residual scaled by samples-per-symbol gives mu; saturate when it exceeds one sample.
    assign mu_ovf  = (residual >> (WACC - SPS_LOG2)) != '0;
    assign mu_next = mu_ovf ? '1 : WMU'(residual >> (WACC - SPS_LOG2 - WMU));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= msk_rx_pkg::ACQ;
            acc       <= '0;
            ctrl_q    <= '0;
            acq_cnt   <= '0;
            strobe_o  <= 1'b0;
            mu_o      <= '0;
            locked_o  <= 1'b0;
            sym_cnt_o <= '0;
        end else begin
            strobe_o <= wrap;
            if (wrap) begin
                mu_o      <= mu_next;
                sym_cnt_o <= sym_cnt_o + 16'd1;
            end

            if (resync_i) begin
                state    <= msk_rx_pkg::ACQ;
                acc      <= '0;
                ctrl_q   <= '0;
                acq_cnt  <= '0;
                locked_o <= 1'b0;
            end else begin
                if (sample_val_i) begin
                    acc <= residual;
                end
                if (ctrl_val_i) begin
                    ctrl_q <= sat_ctrl;
                end
                if (wrap && state == msk_rx_pkg::ACQ) begin
                    if (acq_cnt == ACQ_LAST) begin
                        state    <= msk_rx_pkg::TRACK;
                        locked_o <= 1'b1;
                        acq_cnt  <= '0;
                    end else begin
                        acq_cnt <= acq_cnt + WCNT'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_timing_nco.sv
// tb/tb_timing_nco.sv - scoreboard bench for timing_nco against an arithmetic phase model
module tb_timing_nco;

    localparam longint MOD      = 64'd1 << 24;
    localparam longint NOM      = MOD / 4;
    localparam int     LIM      = 65535;
    localparam int     ACQ_SYMS = 16;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               sample_val_i = 1'b0;
    logic signed [17:0] ctrl_i = '0;
    logic               ctrl_val_i = 1'b0;
    logic               resync_i = 1'b0;
    logic               strobe_o;
    logic [15:0]        mu_o;
    logic               locked_o;
    logic [15:0]        sym_cnt_o;

    timing_nco dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_val_i (sample_val_i),
        .ctrl_i       (ctrl_i),
        .ctrl_val_i   (ctrl_val_i),
        .resync_i     (resync_i),
        .strobe_o     (strobe_o),
        .mu_o         (mu_o),
        .locked_o     (locked_o),
        .sym_cnt_o    (sym_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint edge_no;
        int     mu;
        int     sym;
        bit     locked;
    } exp_t;

    exp_t   sb[$];
    int     n_checks = 0;
    int     n_fail = 0;
    longint edge_n = 0;

    // Model state: phase as a plain integer in [0, 2^24)
    longint m_acc;
    int     m_ctrl;
    bit     m_track;
    int     m_acq;
    int     m_sym;

    always @(posedge clk) edge_n++;

    task automatic chk(input string name, input longint act, input longint exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic int clamp(input int c);
        if (c > LIM) return LIM;
        if (c < -LIM) return -LIM;
        return c;
    endfunction

    task automatic model_reset();
        m_acc   = 0;
        m_ctrl  = 0;
        m_track = 0;
        m_acq   = 0;
        m_sym   = 0;
        sb.delete();
    endtask

    // Drive one cycle of inputs and predict what the next clock edge produces.
    task automatic step(input bit sv, input bit cv, input int c, input bit rs);
        longint s;
        longint r4;
        bit     wrap;
        bit     nt;
        int     mu;
        @(negedge clk);
        sample_val_i = sv;
        ctrl_val_i   = cv;
        ctrl_i       = 18'(c);
        resync_i     = rs;
        wrap = 0;
        s    = m_acc;
        nt   = m_track;
        if (sv) begin
            s = m_acc + NOM + (m_track ? longint'(m_ctrl) : 64'sd0);
            if (s >= MOD) begin
                wrap = 1;
                s    = s - MOD;
            end
        end
        if (wrap) begin
            m_sym = (m_sym + 1) % 65536;
            r4    = s * 4;
            mu    = (r4 >= MOD) ? 65535 : int'(r4 / 256);
            if (!m_track) begin
                m_acq++;
                if (m_acq == ACQ_SYMS) nt = 1;
            end
            sb.push_back('{edge_no: edge_n + 1, mu: mu, sym: m_sym, locked: rs ? 1'b0 : nt});
        end
        if (rs) begin
            m_acc   = 0;
            m_ctrl  = 0;
            m_acq   = 0;
            m_track = 0;
        end else begin
            m_acc = s;
            if (cv) m_ctrl = clamp(c);
            m_track = nt;
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    exp_t e;
    always @(posedge clk) begin
        #1;
        if (reset_n) begin
            if (strobe_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_strobe", strobe_o, 0);
                end else begin
                    e = sb.pop_front();
                    chk("strobe_edge", edge_n, e.edge_no);
                    chk("mu", mu_o, e.mu);
                    chk("sym_cnt", sym_cnt_o, e.sym);
                    chk("locked_at_strobe", locked_o, e.locked);
                end
            end else if (sb.size() != 0 && sb[0].edge_no <= edge_n) begin
                chk("strobe_present", strobe_o, 1);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_strobe", strobe_o, 0);
        chk("rst_mu", mu_o, 0);
        chk("rst_locked", locked_o, 0);
        chk("rst_sym_cnt", sym_cnt_o, 0);
        reset_n = 1'b1;

        // Nominal rate: acquisition then lock at the 16th strobe
        for (int i = 0; i < 80; i++) step(1, 0, 0, 0);
        settle();
        chk("locked_after_acq", locked_o, m_track);

        // Tracking with positive, over-range, negative and minimum corrections
        step(1, 1, 65535, 0);
        for (int i = 0; i < 150; i++) step(1, 0, 0, 0);
        step(1, 1, 131071, 0);
        for (int i = 0; i < 150; i++) step(1, 0, 0, 0);
        step(1, 1, -65535, 0);
        for (int i = 0; i < 150; i++) step(1, 0, 0, 0);
        step(1, 1, -131072, 0);
        for (int i = 0; i < 40; i++) step(1, 0, 0, 0);

        // Sparse samples, zero correction
        step(0, 1, 0, 0);
        for (int i = 0; i < 120; i++) step((i % 3) == 0, 0, 0, 0);

        // Resync with a simultaneous correction: lock drops and correction is discarded
        settle();
        chk("locked_before_resync", locked_o, 1);
        step(1, 1, 100000, 1);
        settle();
        chk("locked_after_resync", locked_o, 0);
        for (int i = 0; i < 120; i++) step(1, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0,
                 int'($urandom_range(0, 262143)) - 131072,
                 $urandom_range(0, 499) == 0);
        end

        // Asynchronous reset in the middle of a symbol
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0);
        @(negedge clk);
        sample_val_i = 1'b0;
        ctrl_val_i   = 1'b0;
        resync_i     = 1'b0;
        #2;
        chk("pre_async_sym_cnt_nonzero", sym_cnt_o != 0, 1);
        reset_n = 1'b0;
        #1;
        chk("async_strobe", strobe_o, 0);
        chk("async_mu", mu_o, 0);
        chk("async_locked", locked_o, 0);
        chk("async_sym_cnt", sym_cnt_o, 0);
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 40; i++) step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        settle();
        chk("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
